nac_unpack: RTL and testbench
=============================

Name: nac_unpack

Overview:
- Receiving end of the compressed byte stream produced by the NAC compressor's bit-to-byte packer.
- Accepts packed bytes (MSB-first bit order, zero-padded final byte) through a small FIFO.
- Re-serialises the bytes into a valid/ready bit stream for the downstream arithmetic decoder.
- Flags the final bit, discards padding, and signals end of stream.

Parameters:
- FIFO_DEPTH, 2, byte FIFO entries; power of two, ≥2.
- BYTE_W, 8, packed byte width; fixed at 8, exposed for the package constant only.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- comp_data_i  in  8  packed byte; bit 7 is the first bit in the stream.
- comp_data_vld_i  in  1  byte valid.
- comp_data_last_i  in  1  qualifies comp_data_i as the final byte of the stream.
- comp_last_bits_i  in  3  number of valid bits in the final byte; 0 means 8. Ignored when last=0.
- comp_data_rdy_o  out  1  FIFO can accept a byte.
- bit_out_o  out  1  serial data bit.
- bit_out_vld_o  out  1  bit valid.
- bit_out_rdy_i  in  1  decoder accepts the bit.
- bit_last_o  out  1  current bit is the last valid bit of the stream.
- stream_done_o  out  1  one-cycle pulse after the last bit is transferred.
- err_overflow_o  out  1  sticky: a byte was offered while comp_data_rdy_o=0.

Behaviour:
- Reset: all outputs 0, FIFO empty, shifter empty, state IDLE. comp_data_rdy_o returns to 1 on the first cycle after reset deasserts. Reset mid-stream discards all buffered data; no done pulse.
- Byte accept: when comp_data_vld_i & comp_data_rdy_o, write {byte, last, nbits} into the FIFO.
  - nbits = comp_last_bits_i, with 0 mapped to 8; nbits = 8 when last=0.
  - comp_data_rdy_o = (FIFO count < FIFO_DEPTH), registered from the count.
- Overflow: comp_data_vld_i & !comp_data_rdy_o drops the byte and sets err_overflow_o until reset.
- Shifter: 8-bit shift register, 4-bit remaining-bit counter, last flag.
  - bit_out_o = shreg[7]; bit_out_vld_o = (remaining != 0).
  - A transfer occurs when bit_out_vld_o & bit_out_rdy_i. It shifts left by 1 and decrements remaining.
- Load: the shifter loads from the FIFO head when remaining==0, or when remaining==1 and a transfer occurs in the same cycle. The latter gives back-to-back bytes without a bubble. A load pops the FIFO.
  - Simultaneous FIFO push and pop is legal; count is unchanged.
- Latency: byte accepted at cycle t with FIFO and shifter empty gives its first bit valid at t+2 (FIFO write at t, shifter load at t+1, output registered).
- bit_last_o = bit_out_vld_o & shifter-last-flag & (remaining==1).
- Padding: bits beyond nbits in the final byte are never presented.
- State machine:
  - IDLE → SHIFT on the first load.
  - SHIFT → DONE on transfer of the bit with bit_last_o=1.
  - DONE → IDLE after one cycle; stream_done_o=1 only in DONE.
  - Bytes for the next stream may be accepted in any state. Shifter loads are blocked in DONE.
- Decoder stall: bit_out_vld_o and bit_out_o hold stable while bit_out_rdy_i=0.
- Data after last: a new stream begins from the next FIFO entry once IDLE is reached.

Optional Feature:
- Macro NAC_UNPACK_BITCNT_EN.
- Defined: adds output port bit_count_o (16 bits).
  - Counts transferred bits of the current stream; saturates at 0xFFFF.
  - Holds its value through DONE and clears on the IDLE→SHIFT transition.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package nac_pkg: NAC_BYTE_W=8, NAC_NBITS_W=4, and a FIFO entry struct {data[7:0], last, nbits[3:0]}.
- Package nac_pkg: state enum {ST_IDLE, ST_SHIFT, ST_DONE}.
- Sub-module nac_byte_fifo: synchronous FIFO parameterised by depth.
  - Interface: push/pop/full/empty/count, registered outputs.
- Shifter and FSM stay in nac_unpack.

Test Plan:
- Bytes 0xA5, 0x3C, last=0, then 0x80 with last=1 and last_bits=1, rdy_i held 1 → bits 10100101 00111100 1 with no gaps; bit_last_o on the 17th bit; stream_done_o pulse one cycle later.
- Single byte 0xF0, last=1, last_bits=0 → 8 bits 11110000; bit_last_o on the 8th bit.
- Push 4 bytes back-to-back with bit_out_rdy_i=0 → rdy_o drops after FIFO_DEPTH+1 accepts; the 4th byte held until rdy_o=1; err_overflow_o stays 0.
- Drive vld with rdy_o=0 → byte dropped, err_overflow_o=1 until reset_i.
- Random bit_out_rdy_i throttling on a 10-byte stream → output matches a reference bit queue; bit_out_o stable under stall.
- reset_i pulsed mid-byte → next cycle vld=0, last=0, done=0; a fresh stream 0x55 decodes correctly afterwards.

Source files
------------

// File: rtl/nac_pkg.sv
// Shared types and constants for the NAC byte-stream unpacker.
package nac_pkg;

  localparam int NAC_BYTE_W  = 8;
  localparam int NAC_NBITS_W = 4;

  typedef struct packed {
    logic [NAC_BYTE_W-1:0]  data;
    logic                   last;
    logic [NAC_NBITS_W-1:0] nbits;
  } nac_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } nac_state_t;

  // Valid bits carried by a byte: a final byte encodes 8 as 0.
  function automatic logic [NAC_NBITS_W-1:0] nac_nbits(input logic last,
                                                       input logic [2:0] last_bits);
    if (!last || last_bits == 3'd0) return 4'd8;
    return {1'b0, last_bits};
  endfunction

endpackage

// File: rtl/nac_byte_fifo.sv
// Small synchronous FIFO of unpacker entries with registered full/empty/count.
module nac_byte_fifo
  import nac_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  nac_entry_t                 push_data,
  input  logic                       pop,
  output nac_entry_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  nac_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nac_unpack.sv
// Re-serialises packed NAC bytes into an MSB-first valid/ready bit stream.
// Optional NAC_UNPACK_BITCNT_EN adds a per-stream transferred-bit counter.
module nac_unpack
  import nac_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int BYTE_W     = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [BYTE_W-1:0] comp_data_i,
  input  logic              comp_data_vld_i,
  input  logic              comp_data_last_i,
  input  logic [2:0]        comp_last_bits_i,
  output logic              comp_data_rdy_o,
  output logic              bit_out_o,
  output logic              bit_out_vld_o,
  input  logic              bit_out_rdy_i,
  output logic              bit_last_o,
  output logic              stream_done_o,
  output logic              err_overflow_o
`ifdef NAC_UNPACK_BITCNT_EN
  ,
  output logic [15:0]       bit_count_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  nac_entry_t             wr_entry;
  nac_entry_t             head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   out_en_q;
  logic                   accept;
  logic                   load;
  logic                   xfer;
  logic [NAC_BYTE_W-1:0]  shreg;
  logic [NAC_NBITS_W-1:0] rem;
  logic                   last_q;
  nac_state_t             state_q;
  nac_state_t             state_nxt;

  assign comp_data_rdy_o = out_en_q && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept          = comp_data_vld_i && comp_data_rdy_o;

  assign wr_entry.data  = comp_data_i;
  assign wr_entry.last  = comp_data_last_i;
  assign wr_entry.nbits = nac_nbits(comp_data_last_i, comp_last_bits_i);

  nac_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (reset_i),
    .push      (accept),
    .push_data (wr_entry),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // out_en_q keeps rdy low through reset and releases it one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_en_q       <= 1'b0;
      err_overflow_o <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      if (comp_data_vld_i && (!out_en_q || fifo_full)) err_overflow_o <= 1'b1;
    end
  end

  assign bit_out_o     = shreg[NAC_BYTE_W-1];
  assign bit_out_vld_o = (rem != '0);
  assign bit_last_o    = bit_out_vld_o && last_q && (rem == 4'd1);
  assign xfer          = bit_out_vld_o && bit_out_rdy_i;

  // Refill on the final bit of a byte avoids a bubble, but never past the stream's last bit.
  assign load = !fifo_empty && (state_q != ST_DONE) &&
                ((rem == '0) || ((rem == 4'd1) && xfer && !last_q));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shreg  <= '0;
      rem    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      shreg  <= head.data;
      rem    <= head.nbits;
      last_q <= head.last;
    end else if (xfer) begin
      shreg  <= shreg << 1;
      rem    <= rem - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_nxt = ST_SHIFT;
      ST_SHIFT: if (xfer && bit_last_o) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stream_done_o = (state_q == ST_DONE);
  end

`ifdef NAC_UNPACK_BITCNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_count_o <= '0;
    end else if ((state_q == ST_IDLE) && load) begin
      bit_count_o <= '0;
    end else if (xfer && (bit_count_o != 16'hFFFF)) begin
      bit_count_o <= bit_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nac_unpack.sv
// Directed bench for nac_unpack: bit order, padding, flow control, overflow and reset.
module tb_nac_unpack;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] comp_data_i;
  logic       comp_data_vld_i;
  logic       comp_data_last_i;
  logic [2:0] comp_last_bits_i;
  logic       comp_data_rdy_o;
  logic       bit_out_o;
  logic       bit_out_vld_o;
  logic       bit_out_rdy_i;
  logic       bit_last_o;
  logic       stream_done_o;
  logic       err_overflow_o;
`ifdef NAC_UNPACK_BITCNT_EN
  logic [15:0] bit_count_o;
`endif

  nac_unpack #(.FIFO_DEPTH(2), .BYTE_W(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .comp_data_i      (comp_data_i),
    .comp_data_vld_i  (comp_data_vld_i),
    .comp_data_last_i (comp_data_last_i),
    .comp_last_bits_i (comp_last_bits_i),
    .comp_data_rdy_o  (comp_data_rdy_o),
    .bit_out_o        (bit_out_o),
    .bit_out_vld_o    (bit_out_vld_o),
    .bit_out_rdy_i    (bit_out_rdy_i),
    .bit_last_o       (bit_last_o),
    .stream_done_o    (stream_done_o),
    .err_overflow_o   (err_overflow_o)
`ifdef NAC_UNPACK_BITCNT_EN
    ,
    .bit_count_o      (bit_count_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done_cyc = 0;
  int n_done = 0;
  bit done_seen = 1'b0;
  bit stall_chk_en = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_bit = 1'b0;
  bit got_bits[$];
  bit got_last[$];
  int got_cyc[$];
  bit ref_bits[$];
  logic [7:0] t5_bytes [10] = '{8'h3A, 8'hC5, 8'h7E, 8'h01, 8'hFF,
                                8'h00, 8'h96, 8'h5B, 8'hE4, 8'hA0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc++;

  // Transfers are recorded at the negedge preceding the accepting posedge.
  always @(negedge clk) begin
    if (bit_out_vld_o && bit_out_rdy_i) begin
      got_bits.push_back(bit_out_o);
      got_last.push_back(bit_last_o);
      got_cyc.push_back(cyc);
    end
    if (stream_done_o) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      n_done++;
    end
    if (stall_chk_en && prev_stall) begin
      chk("stall_vld", bit_out_vld_o, 1'b1);
      chk("stall_bit", bit_out_o, prev_bit);
    end
    prev_stall = bit_out_vld_o && !bit_out_rdy_i;
    prev_bit   = bit_out_o;
  end

  task automatic clear_stream();
    got_bits.delete();
    got_last.delete();
    got_cyc.delete();
    ref_bits.delete();
    done_seen = 1'b0;
  endtask

  task automatic add_ref(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) ref_bits.push_back(b[7-i]);
  endtask

  // Waits for rdy before raising vld so no byte is ever offered while rdy=0.
  task automatic send(input logic [7:0] b, input logic last, input logic [2:0] lb);
    int i;
    for (i = 0; i < 400; i++) begin
      if (comp_data_rdy_o) break;
      @(posedge clk); #1;
    end
    if (i == 400) chk("send_rdy_timeout", 0, 1);
    comp_data_i      = b;
    comp_data_last_i = last;
    comp_last_bits_i = lb;
    comp_data_vld_i  = 1'b1;
    @(posedge clk); #1;
    comp_data_vld_i  = 1'b0;
    comp_data_last_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_seen) break;
    end
    chk({tag, "_done_seen"}, done_seen, 1'b1);
  endtask

  task automatic check_stream(input string tag);
    int nmis = 0;
    int nlast = 0;
    int lastpos = -1;
    chk({tag, "_len"}, got_bits.size(), ref_bits.size());
    for (int i = 0; i < ref_bits.size(); i++) begin
      if (i >= got_bits.size()) nmis++;
      else if (got_bits[i] != ref_bits[i]) nmis++;
    end
    for (int i = 0; i < got_last.size(); i++) begin
      if (got_last[i]) begin
        nlast++;
        lastpos = i;
      end
    end
    chk({tag, "_bit_errs"}, nmis, 0);
    chk({tag, "_nlast"}, nlast, 1);
    chk({tag, "_lastpos"}, lastpos, ref_bits.size() - 1);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", comp_data_rdy_o, 1'b0);
    chk("rst_vld", bit_out_vld_o, 1'b0);
    chk("rst_last", bit_last_o, 1'b0);
    chk("rst_done", stream_done_o, 1'b0);
    chk("rst_ovf", err_overflow_o, 1'b0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy_back", comp_data_rdy_o, 1'b1);
  endtask

  initial begin
    int nd;
    reset_i          = 1'b1;
    comp_data_i      = '0;
    comp_data_vld_i  = 1'b0;
    comp_data_last_i = 1'b0;
    comp_last_bits_i = '0;
    bit_out_rdy_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();

    // Three-byte stream ending with a 1-bit final byte.
    clear_stream();
    add_ref(8'hA5, 8); add_ref(8'h3C, 8); add_ref(8'h80, 1);
    send(8'hA5, 1'b0, 3'd0);
    send(8'h3C, 1'b0, 3'd0);
    send(8'h80, 1'b1, 3'd1);
    wait_done("t1", 200);
    check_stream("t1");
    if (got_cyc.size() == 17) chk("t1_gapless", got_cyc[16] - got_cyc[0], 16);
    else chk("t1_gapless_len", got_cyc.size(), 17);
    if (got_cyc.size() > 0) chk("t1_done_lat", done_cyc - got_cyc[got_cyc.size()-1], 1);
    @(negedge clk); #1;
    chk("t1_done_pulse", stream_done_o, 1'b0);
`ifdef NAC_UNPACK_BITCNT_EN
    chk("t1_bitcnt", bit_count_o, 16'd17);
`endif
    @(posedge clk); #1;

    // Single full final byte (last_bits 0 means 8).
    clear_stream();
    add_ref(8'hF0, 8);
    send(8'hF0, 1'b1, 3'd0);
    wait_done("t2", 200);
    check_stream("t2");
`ifdef NAC_UNPACK_BITCNT_EN
    chk("t2_bitcnt", bit_count_o, 16'd8);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Fill with the decoder stalled: rdy drops after FIFO_DEPTH+1 accepts.
    clear_stream();
    add_ref(8'h11, 8); add_ref(8'h22, 8); add_ref(8'h33, 8); add_ref(8'h44, 8);
    bit_out_rdy_i = 1'b0;
    send(8'h11, 1'b0, 3'd0);
    send(8'h22, 1'b0, 3'd0);
    chk("t3_rdy_after2", comp_data_rdy_o, 1'b1);
    send(8'h33, 1'b0, 3'd0);
    chk("t3_rdy_after3", comp_data_rdy_o, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_rdy_held", comp_data_rdy_o, 1'b0);
    chk("t3_vld_stalled", bit_out_vld_o, 1'b1);
    chk("t3_first_bit", bit_out_o, 1'b0);
    bit_out_rdy_i = 1'b1;
    send(8'h44, 1'b1, 3'd0);
    wait_done("t3", 300);
    check_stream("t3");
    chk("t3_no_ovf", err_overflow_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Offer a byte while rdy=0: dropped, sticky error until reset.
    bit_out_rdy_i = 1'b0;
    send(8'h01, 1'b0, 3'd0);
    send(8'h02, 1'b0, 3'd0);
    send(8'h03, 1'b0, 3'd0);
    chk("t4_full", comp_data_rdy_o, 1'b0);
    comp_data_i     = 8'h99;
    comp_data_vld_i = 1'b1;
    @(posedge clk); #1;
    comp_data_vld_i = 1'b0;
    chk("t4_ovf_set", err_overflow_o, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_ovf_sticky", err_overflow_o, 1'b1);
    nd = n_done;
    pulse_reset();
    bit_out_rdy_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_flushed_vld", bit_out_vld_o, 1'b0);
    chk("t4_no_done", n_done, nd);

    // Ten-byte stream under random decoder throttling.
    clear_stream();
    for (int k = 0; k < 9; k++) add_ref(t5_bytes[k], 8);
    add_ref(t5_bytes[9], 3);
    stall_chk_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) send(t5_bytes[k], k == 9, 3'd3);
      end
      begin
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk); #1;
          bit_out_rdy_i = 1'($urandom_range(0, 1));
          if (done_seen) break;
        end
      end
    join
    stall_chk_en  = 1'b0;
    bit_out_rdy_i = 1'b1;
    wait_done("t5", 50);
    check_stream("t5");
    repeat (2) @(posedge clk);
    #1;

    // Reset while a byte is mid-shift, then a fresh stream.
    clear_stream();
    send(8'hC3, 1'b0, 3'd0);
    send(8'h0F, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    nd = n_done;
    pulse_reset();
    chk("t6_vld", bit_out_vld_o, 1'b0);
    chk("t6_last", bit_last_o, 1'b0);
    chk("t6_done", stream_done_o, 1'b0);
    clear_stream();
    add_ref(8'h55, 8);
    send(8'h55, 1'b1, 3'd0);
    wait_done("t6", 200);
    check_stream("t6");
    chk("t6_one_done", n_done - nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
